// File: rtl/rocc_arb_pkg.sv
// Shared types and constants for the RoCC command/response arbiter
// and the other RoCC-side arbiters.
package rocc_arb_pkg;

    localparam int ROCC_XLEN = 64;
    localparam int ROCC_RD_W = 5;

    typedef struct packed {
        logic [6:0] funct;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic       xd;
        logic       xs1;
        logic       xs2;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rocc_inst_t;

    typedef struct packed {
        rocc_inst_t            inst;
        logic [ROCC_XLEN-1:0]  rs1;
        logic [ROCC_XLEN-1:0]  rs2;
    } rocc_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin grant. The search starts at the pointer register, and
// the pointer moves one past the winner whenever the caller pulses advance.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] hi_idx;
    logic             hi_hit;

    // The lowest requester at or above ptr wins. If there is none, the
    // search wraps and the lowest requester overall wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
            end
            if (req[i] && (IDX_W'(i) >= ptr)) begin
                hi_idx = IDX_W'(i);
                hi_hit = 1'b1;
            end
        end
        grant_valid = |req;
        grant_idx   = hi_hit ? hi_idx : lo_idx;
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/rocc_cmd_arbiter.sv
// Shares one accelerator command/response channel between N RoCC cores. It
// uses round-robin command grant into a one-entry output stage and routes
// responses back by id.
module rocc_cmd_arbiter
    import rocc_arb_pkg::*;
#(
    parameter int N_CORES         = 2,
    parameter int ID_W            = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CORES-1:0]           io_core_cmd_valid,
    output logic [N_CORES-1:0]           io_core_cmd_ready,
    input  logic [N_CORES*32-1:0]        io_core_cmd_bits_inst,
    input  logic [N_CORES*ROCC_XLEN-1:0] io_core_cmd_bits_rs1,
    input  logic [N_CORES*ROCC_XLEN-1:0] io_core_cmd_bits_rs2,
    output logic [N_CORES-1:0]           io_core_resp_valid,
    input  logic [N_CORES-1:0]           io_core_resp_ready,
    output logic [ROCC_RD_W-1:0]         io_core_resp_bits_rd,
    output logic [ROCC_XLEN-1:0]         io_core_resp_bits_data,
    output logic [N_CORES-1:0]           io_core_busy,
    output logic                         io_xf_cmd_valid,
    input  logic                         io_xf_cmd_ready,
    output logic [31:0]                  io_xf_cmd_bits_inst,
    output logic [ROCC_XLEN-1:0]         io_xf_cmd_bits_rs1,
    output logic [ROCC_XLEN-1:0]         io_xf_cmd_bits_rs2,
    output logic [ID_W-1:0]              io_xf_cmd_bits_id,
    input  logic                         io_xf_resp_valid,
    output logic                         io_xf_resp_ready,
    input  logic [ID_W-1:0]              io_xf_resp_bits_id,
    input  logic [ROCC_RD_W-1:0]         io_xf_resp_bits_rd,
    input  logic [ROCC_XLEN-1:0]         io_xf_resp_bits_data
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    rocc_cmd_t            core_cmd [N_CORES];
    rocc_cmd_t            sel_cmd;
    rocc_cmd_t            stage_cmd;
    logic                 stage_full;
    logic [ID_W-1:0]      stage_id;
    logic [CNT_W-1:0]     cnt [N_CORES];
    logic [N_CORES-1:0]   eligible;
    logic [N_CORES-1:0]   cnt_inc;
    logic [N_CORES-1:0]   cnt_dec;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_idx;
    logic                 can_load;
    logic                 cmd_fire;

    // A core whose xd=1 commands already fill its response budget drops out
    // of arbitration. Its xd=0 commands still compete.
    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            core_cmd[i].inst = rocc_inst_t'(io_core_cmd_bits_inst[i*32 +: 32]);
            core_cmd[i].rs1  = io_core_cmd_bits_rs1[i*ROCC_XLEN +: ROCC_XLEN];
            core_cmd[i].rs2  = io_core_cmd_bits_rs2[i*ROCC_XLEN +: ROCC_XLEN];
            eligible[i]      = io_core_cmd_valid[i] &&
                               (!core_cmd[i].inst.xd || (cnt[i] < CNT_W'(MAX_OUTSTANDING)));
        end
    end

    rr_arbiter #(
        .N     (N_CORES),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req         (eligible),
        .advance     (cmd_fire),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign can_load = !stage_full || io_xf_cmd_ready;
    assign cmd_fire = grant_valid && can_load && !reset;

    always_comb begin
        sel_cmd           = '0;
        io_core_cmd_ready = '0;
        cnt_inc           = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_cmd              = core_cmd[i];
                io_core_cmd_ready[i] = cmd_fire;
                cnt_inc[i]           = cmd_fire && core_cmd[i].inst.xd;
            end
        end
    end

    // The stage data is reset as well, because the downstream bits must read
    // zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_full <= 1'b0;
            stage_cmd  <= '0;
            stage_id   <= '0;
        end else if (cmd_fire) begin
            stage_full <= 1'b1;
            stage_cmd  <= sel_cmd;
            stage_id   <= grant_idx;
        end else if (io_xf_cmd_ready) begin
            stage_full <= 1'b0;
        end
    end

    assign io_xf_cmd_valid     = stage_full;
    assign io_xf_cmd_bits_inst = stage_cmd.inst;
    assign io_xf_cmd_bits_rs1  = stage_cmd.rs1;
    assign io_xf_cmd_bits_rs2  = stage_cmd.rs2;
    assign io_xf_cmd_bits_id   = stage_id;

    // An id with no matching core falls through with ready=1, so that
    // response is dropped.
    always_comb begin
        io_core_resp_valid = '0;
        io_xf_resp_ready   = 1'b1;
        for (int i = 0; i < N_CORES; i++) begin
            if (io_xf_resp_bits_id == ID_W'(i)) begin
                io_core_resp_valid[i] = io_xf_resp_valid && !reset;
                io_xf_resp_ready      = io_core_resp_ready[i];
            end
        end
    end

    assign io_core_resp_bits_rd   = io_xf_resp_bits_rd;
    assign io_core_resp_bits_data = io_xf_resp_bits_data;
    assign cnt_dec                = io_core_resp_valid & io_core_resp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CORES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (cnt_dec[i] && !cnt_inc[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            io_core_busy[i] = (cnt[i] != '0) || (stage_full && (stage_id == ID_W'(i)));
        end
    end

    // A response with no matching outstanding command is a protocol error.
    for (genvar g = 0; g < N_CORES; g++) begin : g_underflow_chk
        assert property (@(posedge clk) disable iff (reset) !(cnt_dec[g] && (cnt[g] == '0)));
    end

    if ((1 << ID_W) > N_CORES) begin : g_id_range_chk
        assert property (@(posedge clk) disable iff (reset)
                         !(io_xf_resp_valid && (io_xf_resp_bits_id >= ID_W'(N_CORES))));
    end

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Self-checking bench for rocc_cmd_arbiter. It uses a command scoreboard,
// a response-routing vector table and directed multi-cycle sequences.
module tb_rocc_cmd_arbiter;
    import rocc_arb_pkg::*;

    localparam int N    = 2;
    localparam int ID_W = 1;

    logic                 clk;
    logic                 reset;
    logic [N-1:0]         io_core_cmd_valid;
    logic [N-1:0]         io_core_cmd_ready;
    logic [N*32-1:0]      io_core_cmd_bits_inst;
    logic [N*64-1:0]      io_core_cmd_bits_rs1;
    logic [N*64-1:0]      io_core_cmd_bits_rs2;
    logic [N-1:0]         io_core_resp_valid;
    logic [N-1:0]         io_core_resp_ready;
    logic [4:0]           io_core_resp_bits_rd;
    logic [63:0]          io_core_resp_bits_data;
    logic [N-1:0]         io_core_busy;
    logic                 io_xf_cmd_valid;
    logic                 io_xf_cmd_ready;
    logic [31:0]          io_xf_cmd_bits_inst;
    logic [63:0]          io_xf_cmd_bits_rs1;
    logic [63:0]          io_xf_cmd_bits_rs2;
    logic [ID_W-1:0]      io_xf_cmd_bits_id;
    logic                 io_xf_resp_valid;
    logic                 io_xf_resp_ready;
    logic [ID_W-1:0]      io_xf_resp_bits_id;
    logic [4:0]           io_xf_resp_bits_rd;
    logic [63:0]          io_xf_resp_bits_data;

    rocc_cmd_arbiter #(
        .N_CORES         (N),
        .ID_W            (ID_W),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .io_core_cmd_valid      (io_core_cmd_valid),
        .io_core_cmd_ready      (io_core_cmd_ready),
        .io_core_cmd_bits_inst  (io_core_cmd_bits_inst),
        .io_core_cmd_bits_rs1   (io_core_cmd_bits_rs1),
        .io_core_cmd_bits_rs2   (io_core_cmd_bits_rs2),
        .io_core_resp_valid     (io_core_resp_valid),
        .io_core_resp_ready     (io_core_resp_ready),
        .io_core_resp_bits_rd   (io_core_resp_bits_rd),
        .io_core_resp_bits_data (io_core_resp_bits_data),
        .io_core_busy           (io_core_busy),
        .io_xf_cmd_valid        (io_xf_cmd_valid),
        .io_xf_cmd_ready        (io_xf_cmd_ready),
        .io_xf_cmd_bits_inst    (io_xf_cmd_bits_inst),
        .io_xf_cmd_bits_rs1     (io_xf_cmd_bits_rs1),
        .io_xf_cmd_bits_rs2     (io_xf_cmd_bits_rs2),
        .io_xf_cmd_bits_id      (io_xf_cmd_bits_id),
        .io_xf_resp_valid       (io_xf_resp_valid),
        .io_xf_resp_ready       (io_xf_resp_ready),
        .io_xf_resp_bits_id     (io_xf_resp_bits_id),
        .io_xf_resp_bits_rd     (io_xf_resp_bits_rd),
        .io_xf_resp_bits_data   (io_xf_resp_bits_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     inst;
        logic [63:0]     rs1;
        logic [63:0]     rs2;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [N-1:0]    core_ready;
        logic [N-1:0]    exp_core_valid;
        logic            exp_xf_ready;
    } resp_vec_t;
    resp_vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input int c, input logic xd);
        rocc_inst_t t;
        t.funct  = 7'(c + 1);
        t.rs2    = 5'd2;
        t.rs1    = 5'd1;
        t.xd     = xd;
        t.xs1    = 1'b1;
        t.xs2    = 1'b1;
        t.rd     = 5'(c + 10);
        t.opcode = 7'h0b;
        return t;
    endfunction

    task automatic set_cmd(input int c, input logic v, input logic xd, input logic [63:0] rs1);
        io_core_cmd_valid[c]              = v;
        io_core_cmd_bits_inst[c*32 +: 32] = mk_inst(c, xd);
        io_core_cmd_bits_rs1[c*64 +: 64]  = rs1;
        io_core_cmd_bits_rs2[c*64 +: 64]  = ~rs1;
    endtask

    task automatic set_resp(input logic v, input logic [ID_W-1:0] id, input logic [N-1:0] rdy);
        io_xf_resp_valid   = v;
        io_xf_resp_bits_id = id;
        io_core_resp_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The scoreboard pushes on each core-side acceptance and pops on each
    // downstream transfer. Both are sampled on the falling edge.
    always @(negedge clk) begin
        if (io_xf_cmd_valid && io_xf_cmd_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got id %0d, expected no command", io_xf_cmd_bits_id);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_id", 64'(io_xf_cmd_bits_id), 64'(e.id));
                check("sb_inst", 64'(io_xf_cmd_bits_inst), 64'(e.inst));
                check("sb_rs1", io_xf_cmd_bits_rs1, e.rs1);
                check("sb_rs2", io_xf_cmd_bits_rs2, e.rs2);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (io_core_cmd_valid[i] && io_core_cmd_ready[i]) begin
                sb.push_back('{id: ID_W'(i),
                               inst: io_core_cmd_bits_inst[i*32 +: 32],
                               rs1: io_core_cmd_bits_rs1[i*64 +: 64],
                               rs2: io_core_cmd_bits_rs2[i*64 +: 64]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic exp_id;

        vecs[0] = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 2'b10, 2'b01, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 2'b10, 2'b10, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 2'b01, 2'b10, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 2'b11, 2'b00, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0};

        reset                 = 1'b1;
        io_core_cmd_valid     = '0;
        io_core_cmd_bits_inst = '0;
        io_core_cmd_bits_rs1  = '0;
        io_core_cmd_bits_rs2  = '0;
        io_core_resp_ready    = '0;
        io_xf_cmd_ready       = 1'b0;
        io_xf_resp_valid      = 1'b0;
        io_xf_resp_bits_id    = '0;
        io_xf_resp_bits_rd    = '0;
        io_xf_resp_bits_data  = '0;

        // Reset state
        #5;
        check("rst_xf_valid", 64'(io_xf_cmd_valid), 64'(0));
        check("rst_cmd_ready", 64'(io_core_cmd_ready), 64'(0));
        check("rst_busy", 64'(io_core_busy), 64'(0));
        check("rst_resp_valid", 64'(io_core_resp_valid), 64'(0));
        check("rst_xf_rs1", io_xf_cmd_bits_rs1, 64'(0));
        check("rst_xf_inst", 64'(io_xf_cmd_bits_inst), 64'(0));
        #10 reset = 1'b0;
        step();

        // Single xd=1 command followed by its response
        set_cmd(0, 1'b1, 1'b1, 64'h1234);
        io_xf_cmd_ready = 1'b1;
        #1 check("single_ready", 64'(io_core_cmd_ready), 64'(2'b01));
        step();
        set_cmd(0, 1'b0, 1'b1, 64'h1234);
        check("single_xf_valid", 64'(io_xf_cmd_valid), 64'(1));
        check("single_xf_id", 64'(io_xf_cmd_bits_id), 64'(0));
        check("single_xf_rs1", io_xf_cmd_bits_rs1, 64'h1234);
        check("single_busy_stage", 64'(io_core_busy), 64'(2'b01));
        step();
        check("single_drained", 64'(io_xf_cmd_valid), 64'(0));
        check("single_busy_cnt", 64'(io_core_busy), 64'(2'b01));
        io_xf_resp_bits_rd   = 5'd5;
        io_xf_resp_bits_data = 64'hDEAD;
        set_resp(1'b1, 1'b0, 2'b01);
        #1;
        check("single_resp_valid", 64'(io_core_resp_valid), 64'(2'b01));
        check("single_resp_rd", 64'(io_core_resp_bits_rd), 64'(5));
        check("single_resp_data", io_core_resp_bits_data, 64'hDEAD);
        check("single_xf_resp_ready", 64'(io_xf_resp_ready), 64'(1));
        step();
        set_resp(1'b0, 1'b0, 2'b00);
        check("single_busy_clear", 64'(io_core_busy), 64'(0));

        // Response routing table; valid is dropped again before each edge.
        for (int v = 0; v < 6; v++) begin
            set_resp(vecs[v].valid, vecs[v].id, vecs[v].core_ready);
            #1;
            check($sformatf("vec%0d_core_valid", v), 64'(io_core_resp_valid), 64'(vecs[v].exp_core_valid));
            check($sformatf("vec%0d_xf_ready", v), 64'(io_xf_resp_ready), 64'(vecs[v].exp_xf_ready));
            set_resp(1'b0, 1'b0, 2'b00);
            step();
        end

        // Fairness: the pointer sits at 1 after core 0's grant.
        set_cmd(0, 1'b1, 1'b0, 64'hA0);
        set_cmd(1, 1'b1, 1'b0, 64'hA1);
        exp_id = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("fair%0d_valid", k), 64'(io_xf_cmd_valid), 64'(1));
            check($sformatf("fair%0d_id", k), 64'(io_xf_cmd_bits_id), 64'(exp_id));
            exp_id = ~exp_id;
        end

        // Backpressure: the stage holds core 0's A0 command.
        io_xf_cmd_ready = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 64'hB0);
        set_cmd(1, 1'b1, 1'b0, 64'hB1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d_ready", k), 64'(io_core_cmd_ready), 64'(0));
            check($sformatf("bp%0d_valid", k), 64'(io_xf_cmd_valid), 64'(1));
            check($sformatf("bp%0d_rs1", k), io_xf_cmd_bits_rs1, 64'hA0);
            check($sformatf("bp%0d_busy", k), 64'(io_core_busy), 64'(2'b01));
            step();
        end
        io_xf_cmd_ready = 1'b1;
        #1 check("bp_release_ready", 64'(io_core_cmd_ready), 64'(2'b10));
        step();
        set_cmd(0, 1'b0, 1'b0, 64'hB0);
        set_cmd(1, 1'b0, 1'b0, 64'hB1);
        step();

        // Outstanding limit on core 1
        set_cmd(1, 1'b1, 1'b1, 64'hC1);
        #1 check("lim_first_ready", 64'(io_core_cmd_ready), 64'(2'b10));
        for (int k = 0; k < 4; k++) step();
        check("lim_stall", 64'(io_core_cmd_ready), 64'(0));
        set_cmd(0, 1'b1, 1'b0, 64'hC0);
        #1 check("lim_core0_issue", 64'(io_core_cmd_ready), 64'(2'b01));
        step();
        check("lim_core0_again", 64'(io_core_cmd_ready), 64'(2'b01));
        set_cmd(0, 1'b0, 1'b0, 64'hC0);
        check("lim_busy1", 64'(io_core_busy[1]), 64'(1));
        set_resp(1'b1, 1'b1, 2'b10);
        #1;
        check("lim_resp_cycle_ready", 64'(io_core_cmd_ready), 64'(0));
        check("lim_resp_valid", 64'(io_core_resp_valid), 64'(2'b10));
        step();
        set_resp(1'b0, 1'b0, 2'b00);
        #1 check("lim_after_resp_ready", 64'(io_core_cmd_ready), 64'(2'b10));
        step();
        set_cmd(1, 1'b0, 1'b1, 64'hC1);
        set_resp(1'b1, 1'b1, 2'b10);
        for (int k = 0; k < 4; k++) step();
        set_resp(1'b0, 1'b0, 2'b00);
        check("lim_busy_clear", 64'(io_core_busy), 64'(0));

        // Same-cycle increment and decrement on core 0 with cnt[0]=2
        set_cmd(0, 1'b1, 1'b1, 64'hD0);
        step();
        step();
        set_resp(1'b1, 1'b0, 2'b01);
        #1;
        check("incdec_cmd_ready", 64'(io_core_cmd_ready), 64'(2'b01));
        check("incdec_resp_valid", 64'(io_core_resp_valid), 64'(2'b01));
        step();
        set_cmd(0, 1'b0, 1'b1, 64'hD0);
        step();
        check("incdec_cnt1_busy", 64'(io_core_busy), 64'(2'b01));
        step();
        set_resp(1'b0, 1'b0, 2'b00);
        check("incdec_cnt0_busy", 64'(io_core_busy), 64'(0));

        // Asynchronous reset mid-stream
        io_xf_cmd_ready = 1'b0;
        set_cmd(0, 1'b1, 1'b1, 64'hE0);
        set_cmd(1, 1'b1, 1'b1, 64'hE1);
        step();
        check("ar_pre_valid", 64'(io_xf_cmd_valid), 64'(1));
        check("ar_pre_id", 64'(io_xf_cmd_bits_id), 64'(1));
        check("ar_pre_busy", 64'(io_core_busy), 64'(2'b10));
        set_resp(1'b1, 1'b0, 2'b00);
        #1 check("ar_pre_resp_valid", 64'(io_core_resp_valid), 64'(2'b01));
        #1 reset = 1'b1;
        #1;
        check("ar_xf_valid", 64'(io_xf_cmd_valid), 64'(0));
        check("ar_busy", 64'(io_core_busy), 64'(0));
        check("ar_resp_valid", 64'(io_core_resp_valid), 64'(0));
        check("ar_cmd_ready", 64'(io_core_cmd_ready), 64'(0));
        check("ar_xf_rs1", io_xf_cmd_bits_rs1, 64'(0));
        sb.delete();
        set_resp(1'b0, 1'b0, 2'b00);
        io_xf_cmd_ready = 1'b1;
        #2 reset = 1'b0;
        #1 check("ar_post_ready", 64'(io_core_cmd_ready), 64'(2'b01));
        step();
        check("ar_post_valid", 64'(io_xf_cmd_valid), 64'(1));
        check("ar_post_id", 64'(io_xf_cmd_bits_id), 64'(0));
        set_cmd(0, 1'b0, 1'b1, 64'hE0);
        set_cmd(1, 1'b0, 1'b1, 64'hE1);
        step();
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rocc_cmd_arbiter.md
Name: rocc_cmd_arbiter

Overview:
- Shares the single accelerator command/response channel (X-Files arbiter input) between N RoCC cores.
- Round-robin grant on commands into a one-entry registered output stage; each forwarded command is tagged with the source core id.
- Responses are routed back by returned id.
- Per-core outstanding-response counters drive each core's busy and gate that core's command acceptance.

Parameters:
- N_CORES, 2, number of RoCC requester ports.
- ID_W, 1, core id width; must equal max(1, clog2(N_CORES)).
- MAX_OUTSTANDING, 4, max in-flight xd=1 commands per core; counter width clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- io_core_cmd_valid  in  N_CORES  per-core command valid.
- io_core_cmd_ready  out  N_CORES  per-core command ready.
- io_core_cmd_bits_inst  in  N_CORES*32  per-core {funct[6:0],rs2[4:0],rs1[4:0],xd,xs1,xs2,rd[4:0],opcode[6:0]}.
- io_core_cmd_bits_rs1  in  N_CORES*64  per-core rs1 value.
- io_core_cmd_bits_rs2  in  N_CORES*64  per-core rs2 value.
- io_core_resp_valid  out  N_CORES  per-core response valid.
- io_core_resp_ready  in  N_CORES  per-core response ready.
- io_core_resp_bits_rd  out  5  response rd, shared bus, qualified by resp_valid.
- io_core_resp_bits_data  out  64  response data, shared bus.
- io_core_busy  out  N_CORES  core has a buffered or outstanding command.
- io_xf_cmd_valid  out  1  downstream command valid.
- io_xf_cmd_ready  in  1  downstream command ready.
- io_xf_cmd_bits_inst  out  32  forwarded instruction.
- io_xf_cmd_bits_rs1  out  64  forwarded rs1.
- io_xf_cmd_bits_rs2  out  64  forwarded rs2.
- io_xf_cmd_bits_id  out  ID_W  source core id.
- io_xf_resp_valid  in  1  downstream response valid.
- io_xf_resp_ready  out  1  downstream response ready.
- io_xf_resp_bits_id  in  ID_W  destination core id.
- io_xf_resp_bits_rd  in  5  response rd.
- io_xf_resp_bits_data  in  64  response data.

Behaviour:
- Reset (async assert, sync release):
  - Output stage empty; io_xf_cmd_valid=0; all counters 0.
  - RR pointer=0, so core 0 has top priority.
  - All cmd_ready=0, resp_valid=0, busy=0; data outputs 0.
- Output stage:
  - One entry {inst,rs1,rs2,id}; io_xf_cmd_valid=full; bits come directly from registers.
  - Stage can load when empty, or when full and io_xf_cmd_ready=1 in the same cycle (full throughput, 1 cmd/cycle).
- Eligibility and grant:
  - Core i is eligible when cmd_valid[i] && (xd==0 || cnt[i]<MAX_OUTSTANDING).
  - Grant goes to the first eligible core at or after the RR pointer, wrapping modulo N_CORES.
  - cmd_ready[i] = can_load && grant==i.
  - Ready never depends on the core's own valid beyond the grant decision, so no combinational loop with the downstream.
  - On a fire: the stage loads and the pointer becomes (grant+1) mod N_CORES.
  - With no fire, the pointer holds.
- Latency: a command accepted in cycle t is valid downstream in cycle t+1.
- Counters:
  - cnt[i] increments when core i's cmd fires with xd=1.
  - cnt[i] decrements when a response for core i fires.
  - Simultaneous increment and decrement on the same core: counter holds.
  - Increment at MAX_OUTSTANDING is impossible because eligibility forbids it.
  - Response fire with cnt==0 is a protocol error: counter saturates at 0, and an assertion fires in simulation.
- Response path, combinational, zero latency:
  - io_core_resp_valid[id]=io_xf_resp_valid; all other bits 0.
  - io_xf_resp_ready=io_core_resp_ready[id].
  - rd/data pass straight through.
  - A response id >= N_CORES is dropped: resp_ready=1, no core valid, assertion fires.
- Busy: busy[i] = (cnt[i]!=0) || (stage full && stage id==i). It is registered-state derived, with no combinational input path.
- Reset mid-operation: the buffered command and all counters are discarded; downstream must be reset in the same cycle.

Decomposition:
- Shared package rocc_arb_pkg holds:
  - typedef rocc_inst_t: packed 32-bit instruction, field order as in Ports.
  - typedef rocc_cmd_t: {inst,rs1,rs2}.
  - Constants ROCC_XLEN=64 and ROCC_RD_W=5.
- One sub-module is natural: rr_arbiter, a parameterised N-way round-robin grant with a pointer register and an advance input. It is reusable for the memory-side arbiter.

Test Plan:
- Single command: core 0 sends xd=1 rs1=0x1234 with xf_cmd_ready=1.
  - xf_cmd_valid rises the next cycle with id=0 and rs1=0x1234.
  - busy[0]=1 until a response with id=0, rd=5, data=0xDEAD fires at core 0; then busy[0]=0.
- Fairness: both cores hold valid continuously with xf_cmd_ready=1 and xd=0.
  - Downstream ids alternate 0,1,0,1 for 8 cycles; throughput is 1 cmd/cycle.
- Backpressure: xf_cmd_ready=0 for 5 cycles with the stage full.
  - Both cmd_ready=0; downstream bits stable.
  - Ready reasserts on the cycle xf_cmd_ready=1.
- Outstanding limit: core 1 issues 4 xd=1 commands with no responses.
  - The 5th command stalls: cmd_ready[1]=0 while core 0 still issues.
  - One id=1 response fires, then core 1 is accepted next cycle.
- Same-cycle increment and decrement: core 0 command (xd=1) and id=0 response fire together with cnt[0]=2 → cnt[0] stays 2.
- Async reset: assert reset mid-stream, between clock edges.
  - xf_cmd_valid, all resp_valid and all busy go to 0 immediately.
  - After release, the first grant goes to core 0.
